// File: rtl/ahb_rr_sched.sv
// ahb_rr_sched: round-robin owner scheduler for a shared AHB master port.
// Define AHB_RR_QUANTUM_EN to add the NONSEQ quantum counter and its forced hand-over.
module ahb_rr_sched #(
  parameter int g_nreq    = 4,
  parameter int g_quantum = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [g_nreq-1:0] req,
  input  logic [1:0]        m_htrans,
  input  logic              m_hready,
  output logic [g_nreq-1:0] grant,
  output logic [g_nreq-1:0] downer,
  output logic [g_nreq-1:0] pending,
  output logic [g_nreq-1:0] capture,
  output logic              busy
);
  localparam int PW = $clog2(g_nreq);

  typedef enum logic {IDLE, LOCK} state_t;

  if (g_nreq < 2 || g_nreq > 8) begin : g_bad_nreq
    $error("ahb_rr_sched: g_nreq must be 2..8");
  end
  if (g_quantum < 1 || g_quantum > 255) begin : g_bad_quantum
    $error("ahb_rr_sched: g_quantum must be 1..255");
  end

  function automatic logic [g_nreq-1:0] rr_pick(input logic [g_nreq-1:0] c,
                                                input logic [PW-1:0]     ptr);
    logic [g_nreq-1:0] w;
    logic              found;
    int                idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= g_nreq; k++) begin
      idx = (int'(ptr) + k) % g_nreq;
      if (!found && c[idx]) begin
        w[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] oh2idx(input logic [g_nreq-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < g_nreq; i++) begin
      if (v[i]) r = PW'(i);
    end
    return r;
  endfunction

  state_t            state;
  logic [PW-1:0]     lptr;
  logic [g_nreq-1:0] cand;
  logic [g_nreq-1:0] others;
  logic [g_nreq-1:0] pool;
  logic [g_nreq-1:0] winner;
  logic              is_idle;
  logic              is_nonseq;
  logic              accept;
  logic              quantum_hit;
  logic              release_w;
  logic              load_grant;

  assign is_idle   = (m_htrans == 2'b00);
  assign is_nonseq = (m_htrans == 2'b10);
  assign accept    = m_hready && is_nonseq;
  assign cand      = pending | req;
  assign others    = cand & ~grant;
  // The released owner only wins again when nobody else is waiting.
  assign pool      = (|others) ? others : cand;
  assign winner    = rr_pick(pool, lptr);

  assign release_w  = (state == LOCK) && m_hready &&
                      (is_idle || (is_nonseq && quantum_hit && (|others)));
  assign load_grant = m_hready && (|cand) && ((state == IDLE) || release_w);
  assign capture    = req & (~grant | {g_nreq{release_w}});
  assign busy       = (state == LOCK);

`ifdef AHB_RR_QUANTUM_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] q);
    return (q == 8'hFF) ? q : q + 8'd1;
  endfunction

  logic [7:0] qcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt <= '0;
    end else if (load_grant) begin
      qcnt <= '0;
    end else if (state == LOCK && accept) begin
      qcnt <= sat_inc(qcnt);
    end
  end

  assign quantum_hit = (qcnt >= 8'(g_quantum - 1));
`else
  assign quantum_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      downer  <= '0;
      pending <= '0;
      lptr    <= PW'(g_nreq - 1);
    end else begin
      // A fresh capture outranks the clear of an accepted replay.
      pending <= capture | (pending & ~(grant & {g_nreq{accept}}));
      if (m_hready) begin
        downer <= is_idle ? '0 : grant;
        if (load_grant) begin
          grant <= winner;
          lptr  <= oh2idx(winner);
          state <= LOCK;
        end else if (state == IDLE || release_w) begin
          grant <= '0;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_sched.sv
// Scoreboard bench for ahb_rr_sched: directed scenarios plus random traffic vs. a behavioural model.
module tb_ahb_rr_sched;
  localparam int N = 4;
  localparam int Q = 2;
`ifdef AHB_RR_QUANTUM_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [1:0]   m_htrans;
  logic         m_hready;
  logic [N-1:0] grant, downer, pending, capture;
  logic         busy;

  ahb_rr_sched #(.g_nreq(N), .g_quantum(Q)) dut (
    .clk(clk), .rst(rst), .req(req), .m_htrans(m_htrans), .m_hready(m_hready),
    .grant(grant), .downer(downer), .pending(pending), .capture(capture), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] downer;
    logic [N-1:0] pending;
    logic [N-1:0] capture;
    logic         busy;
    bit           fix;
    logic [N-1:0] fix_grant;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   errors = 0;
  int   checks = 0;

  // Reference model: owner / data owner as indices (-1 = none), last winner, quantum count.
  int       own, dwn, last, cnt;
  bit [N-1:0] pend;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Winner is the member of the set closest after 'after' going upward with wrap.
  function automatic int choose(input bit [N-1:0] set, input int after);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - after - 1 + N) % N;
      if (set[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    own  = -1;
    dwn  = -1;
    last = N - 1;
    cnt  = 0;
    pend = '0;
  endtask

  task automatic cycle(input logic r_rst, input logic [N-1:0] r, input logic [1:0] t,
                       input logic h, input bit fix, input logic [N-1:0] fg);
    exp_t       e;
    bit [N-1:0] cand, oth, cap, pool;
    bit         rel;
    rst = r_rst; req = r; m_htrans = t; m_hready = h;
    if (r_rst) model_reset();
    cand = pend | r;
    oth  = cand & ~oh(own);
    rel  = (own >= 0) && h &&
           (t == T_IDLE || (QEN && t == T_NSEQ && cnt >= Q - 1 && oth != 0));
    for (int i = 0; i < N; i++) cap[i] = r[i] && (own != i || rel);
    e.grant = oh(own); e.downer = oh(dwn); e.pending = pend; e.capture = cap;
    e.busy = (own >= 0); e.fix = fix; e.fix_grant = fg;
    sb.push_back(e);
    if (!r_rst) begin
      if (own >= 0 && h && t == T_NSEQ) pend[own] = 1'b0;
      pend = pend | cap;
      if (h) begin
        dwn = (t == T_IDLE) ? -1 : own;
        if (own < 0) begin
          if (cand != 0) begin own = choose(cand, last); last = own; cnt = 0; end
        end else if (rel) begin
          pool = (oth != 0) ? oth : cand;
          if (cand == 0) own = -1;
          else begin own = choose(pool, last); last = own; cnt = 0; end
        end else if (t == T_NSEQ && cnt < 255) begin
          cnt++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic r_rst, input logic [N-1:0] r, input logic [1:0] t, input logic h);
    cycle(r_rst, r, t, h, 1'b0, '0);
  endtask

  task automatic cycf(input logic [N-1:0] r, input logic [1:0] t, input logic h,
                      input logic [N-1:0] fg);
    cycle(1'b0, r, t, h, 1'b1, fg);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: compares the oldest expectation against the DUT mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("grant",   8'(grant),   8'(me.grant));
        chk("downer",  8'(downer),  8'(me.downer));
        chk("pending", 8'(pending), 8'(me.pending));
        chk("capture", 8'(capture), 8'(me.capture));
        chk("busy",    8'(busy),    8'(me.busy));
        if (me.fix) chk("grant_fixed", 8'(grant), 8'(me.fix_grant));
      end
    end
  end

  initial begin
    logic [1:0] t;
    int         w;
    rst = 1'b1; req = '0; m_htrans = T_IDLE; m_hready = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Reset, then a single request is granted on the next edge.
    for (int i = 0; i < 3; i++) cycle(1'b1, '0, T_IDLE, 1'b1, 1'b1, '0);
    cycf(4'b0001, T_IDLE, 1'b1, 4'b0000);
    cycf(4'b0000, T_NSEQ, 1'b1, 4'b0001);
    cyc(1'b0, 4'b0000, T_IDLE, 1'b1);

    // Round robin with everyone requesting.
    cyc(1'b1, '0, T_IDLE, 1'b1);
    for (int k = 0; k <= 8; k++)
      cycle(1'b0, 4'b1111, (k % 2 == 0) ? T_NSEQ : T_IDLE, 1'b1, k >= 1, oh((k / 2) % 4));

    // Port0 streams NONSEQ while port2 waits.
    cyc(1'b1, '0, T_IDLE, 1'b1);
    cyc(1'b0, 4'b0001, T_IDLE, 1'b1);
    cycf(4'b0101, T_NSEQ, 1'b1, 4'b0001);
    cycf(4'b0101, T_NSEQ, 1'b1, 4'b0001);
`ifdef AHB_RR_QUANTUM_EN
    cycf(4'b0101, T_NSEQ, 1'b1, 4'b0100);
    cyc(1'b0, 4'b0101, T_NSEQ, 1'b1);
    cyc(1'b0, 4'b0100, T_IDLE, 1'b1);
    cyc(1'b0, 4'b0100, T_NSEQ, 1'b1);
`else
    cycf(4'b0101, T_NSEQ, 1'b1, 4'b0001);
    cycf(4'b0101, T_NSEQ, 1'b1, 4'b0001);
    cycf(4'b0100, T_IDLE, 1'b1, 4'b0001);
    cycf(4'b0100, T_NSEQ, 1'b1, 4'b0100);
`endif

    // Burst from port1 is not split by port3's request.
    cyc(1'b1, '0, T_IDLE, 1'b1);
    cyc(1'b0, 4'b0010, T_IDLE, 1'b1);
    cycf(4'b1000, T_NSEQ, 1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) cycf(4'b0000, T_SEQ, 1'b1, 4'b0010);
    cycf(4'b0000, T_IDLE, 1'b1, 4'b0010);
    cycf(4'b0000, T_IDLE, 1'b1, 4'b1000);

    // Wait states mid-transfer while new requests arrive.
    cyc(1'b1, '0, T_IDLE, 1'b1);
    cyc(1'b0, 4'b0001, T_IDLE, 1'b1);
    cycf(4'b0000, T_NSEQ, 1'b1, 4'b0001);
    for (int i = 0; i < 5; i++)
      cycf((i % 2 == 0) ? 4'b0110 : 4'b1000, T_NSEQ, 1'b0, 4'b0001);
    cycf(4'b0000, T_IDLE, 1'b1, 4'b0001);
    cyc(1'b0, 4'b0000, T_IDLE, 1'b1);

    // Reset mid-burst discards pending requests.
    cyc(1'b0, 4'b0011, T_IDLE, 1'b1);
    cyc(1'b0, 4'b0100, T_NSEQ, 1'b1);
    cyc(1'b0, 4'b1000, T_SEQ, 1'b1);
    cycle(1'b1, 4'b0000, T_SEQ, 1'b1, 1'b1, 4'b0000);
    cycf(4'b0000, T_IDLE, 1'b1, 4'b0000);
    cycf(4'b0000, T_IDLE, 1'b1, 4'b0000);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      w = $urandom_range(0, 19);
      t = (w < 10) ? T_NSEQ : (w < 13) ? T_IDLE : (w < 18) ? T_SEQ : T_BUSY;
      cyc($urandom_range(0, 249) == 0, N'($urandom_range(0, 15)), t,
          $urandom_range(0, 3) != 0);
    end

    rst = 1'b0; req = '0; m_htrans = T_IDLE; m_hready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
